// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit paths:
//   OSR         - line oversample ratio (samples per bit)
//   rx_state_t  - receiver frame-recovery states
//   baud_div()  - sysclk cycles per oversample tick, rounded to nearest
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OSR = 16;

  typedef enum logic [2:0] {
    IDLE,   // line idle, waiting for a falling edge
    START,  // qualifying the start bit at its midpoint
    DATA,   // sampling the eight data bits
    STOP,   // sampling the stop bit
    BREAK   // stop bit was low; wait for the line to return high
  } rx_state_t;

  // Round-to-nearest divisor so the tick rate error stays symmetric.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OSR) / 2) / (baud * OSR);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// CPU-facing receive port of the UART receiver.
//   rx_ack     - one-cycle pulse from the CPU: consume byte, clear error flags
//   rx_data    - last received byte
//   rx_status  - byte valid, sticky until rx_ack
//   frame_err  - sticky, a stop bit was sampled low
//   overrun    - sticky, a byte completed while rx_status was already set
// Modports: slave = receiver side, master = CPU bus side.
// -----------------------------------------------------------------------------
interface uart_rx_if;

  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       overrun;

  modport slave (
    input  rx_ack,
    output rx_data,
    output rx_status,
    output frame_err,
    output overrun
  );

  modport master (
    output rx_ack,
    input  rx_data,
    input  rx_status,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing one oversample tick every DIV sysclk cycles.
// Shared by the UART receiver and transmitter.
//   sysclk   - clock
//   reset    - synchronous, active-high
//   restart  - force the divider back to 0 (re-phases ticks to a line edge)
//   tick     - one-cycle pulse while the divider sits at DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 326
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a value before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order across processes.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial byte receiver with 16x oversampling. Each completed byte is held
// with a sticky valid flag until the CPU acknowledges it, so a slow poller
// never loses the most recent byte (older unread bytes raise overrun).
//   sysclk    - the only clock
//   reset     - synchronous, active-high
//   uart_rxd  - asynchronous serial input, idle high
//   bus       - CPU receive port (uart_rx_if.slave): rx_ack in; rx_data,
//               rx_status, frame_err, overrun out (all registered)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OSR    = 16,
  parameter int DIV    = uart_pkg::baud_div(CLK_HZ, BAUD)
) (
  input  logic      sysclk,
  input  logic      reset,
  input  logic      uart_rxd,
  uart_rx_if.slave  bus
);

  import uart_pkg::*;

  // Sample-counter values marking mid start bit and the end of a bit period.
  localparam logic [3:0] SC_MID  = 4'(OSR / 2 - 1);
  localparam logic [3:0] SC_LAST = 4'(OSR - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic       sync1_q, sync1_d;
  logic       rxs_q, rxs_d;
  rx_state_t  state_q, state_d;
  logic [3:0] sc_q, sc_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_status_q, rx_status_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic       tick;
  logic       restart;
  logic       good_stop;
  logic       bad_stop;

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level so reset
  // release never looks like a start edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = uart_rxd;
    rxs_d   = sync1_q;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state, sample counter, bit counter, shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    sc_d      = tick ? (sc_q + 4'd1) : sc_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    restart   = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          // Re-phase the divider to the edge so mid-bit sampling is centred.
          restart = 1'b1;
          sc_d    = '0;
          state_d = START;
        end
      end

      START: begin
        if (tick && (sc_q == SC_MID)) begin
          if (rxs_q) begin
            state_d = IDLE;          // glitch shorter than half a bit
          end else begin
            sc_d     = '0;           // from here sc==15 is mid-bit
            bitcnt_d = '0;
            state_d  = DATA;
          end
        end
      end

      DATA: begin
        if (tick && (sc_q == SC_LAST)) begin
          shreg_d  = {rxs_q, shreg_q[7:1]};   // LSB arrives first
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (tick && (sc_q == SC_LAST)) begin
          if (rxs_q) begin
            good_stop = 1'b1;
            state_d   = IDLE;        // leave at mid-stop: zero-gap frames work
          end else begin
            bad_stop  = 1'b1;
            state_d   = BREAK;
          end
        end
      end

      BREAK: begin
        // A line held low must return high before another start is accepted.
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // CPU-visible flags. Acknowledge clears first; a same-cycle frame event then
  // takes precedence, so a byte landing with rx_ack is never lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_status_d = rx_status_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (bus.rx_ack) begin
      rx_status_d = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (good_stop) begin
      rx_data_d   = shreg_q;
      rx_status_d = 1'b1;
      // The previous byte is only lost if the CPU did not take it this cycle.
      if (rx_status_q && !bus.rx_ack) begin
        overrun_d = 1'b1;
      end
    end

    if (bad_stop) begin
      frame_err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      sc_q        <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered, no combinational path from inputs)
  // ---------------------------------------------------------------------------
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_status = rx_status_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. The clock/baud pair is chosen so one
// oversample tick is 4 sysclk cycles (bit period 64 cycles), keeping runs short.
// Directed scenarios cover reset, latency, glitch rejection, framing error,
// overrun, ack collision and mid-frame reset; a random phase drives frames
// through a scoreboard that a separate monitor drains and acknowledges.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_HZ  = 614_400;
  localparam int BAUD    = 9600;
  localparam int DIV     = 4;                    // (614400+76800)/153600
  localparam int P       = DIV * 16;             // sysclk cycles per bit
  localparam int LAT_NOM = (19 * P) / 2 + 3;     // 9.5 bit periods + 3 cycles
  localparam int N_RAND  = 30;

  logic sysclk   = 1'b0;
  logic reset    = 1'b1;
  logic uart_rxd = 1'b1;
  logic mon_ack  = 1'b0;
  logic dir_ack  = 1'b0;
  logic auto_ack = 1'b0;

  uart_rx_if rx_bus ();
  assign rx_bus.rx_ack = mon_ack | dir_ack;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .bus      (rx_bus)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = -1;
  logic prev_status = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  always @(posedge sysclk) cyc <= cyc + 1;

  // Records the cycle at which rx_status goes 0 -> 1.
  always @(negedge sysclk) begin
    if (rx_bus.rx_status && !prev_status) rise_cyc = cyc;
    prev_status = rx_bus.rx_status;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns one cycle after a rising edge, away from the sampling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // One 8N1 frame, LSB first; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    wait_cyc(P);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cyc(P);
    end
    uart_rxd = stop_bit;
    wait_cyc(P);
  endtask

  task automatic dir_ack_pulse();
    dir_ack = 1'b1;
    wait_cyc(1);
    dir_ack = 1'b0;
    wait_cyc(1);
  endtask

  // Monitor: whenever the receiver presents a byte or an error, compare it with
  // the oldest expected frame and acknowledge it like the CPU would.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (auto_ack && (rx_bus.rx_status || rx_bus.frame_err)) begin
        check("sb_expected_pending", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_frame_err", rx_bus.frame_err, e.err);
          check("sb_status", rx_bus.rx_status, !e.err);
          if (!e.err) check("sb_data", rx_bus.rx_data, e.data);
          check("sb_overrun", rx_bus.overrun, 0);
        end
        @(posedge sysclk); #1 mon_ack = 1'b1;
        @(posedge sysclk); #1 mon_ack = 1'b0;
      end
    end
  end

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t0;
    int to;
    logic [7:0] b;
    logic       stp;

    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);

    // Reset state
    check("rst_data", rx_bus.rx_data, 8'h00);
    check("rst_status", rx_bus.rx_status, 0);
    check("rst_frame_err", rx_bus.frame_err, 0);
    check("rst_overrun", rx_bus.overrun, 0);

    // 0x5A, no ack: value, flags and latency from the start edge
    rise_cyc = -1;
    t0 = cyc;
    send_frame(8'h5A, 1'b1);
    to = 0;
    while (rise_cyc < 0 && to < 4 * P) begin
      wait_cyc(1);
      to++;
    end
    check("t1_status", rx_bus.rx_status, 1);
    lat = (rise_cyc < 0) ? -1000 : (rise_cyc - t0);
    check("t1_latency_window", (lat >= LAT_NOM - DIV) && (lat <= LAT_NOM + DIV), 1);
    if (rise_cyc < 0) lat = LAT_NOM;
    check("t1_data", rx_bus.rx_data, 8'h5A);
    check("t1_frame_err", rx_bus.frame_err, 0);
    check("t1_overrun", rx_bus.overrun, 0);
    dir_ack_pulse();
    check("t1_ack_clears_status", rx_bus.rx_status, 0);

    // Short low glitch is rejected, next frame still received
    uart_rxd = 1'b0;
    wait_cyc(20);
    uart_rxd = 1'b1;
    wait_cyc(2 * P);
    check("t2_glitch_status", rx_bus.rx_status, 0);
    check("t2_glitch_frame_err", rx_bus.frame_err, 0);
    send_frame(8'hC3, 1'b1);
    check("t2_data", rx_bus.rx_data, 8'hC3);
    check("t2_status", rx_bus.rx_status, 1);
    check("t2_frame_err", rx_bus.frame_err, 0);
    dir_ack_pulse();

    // Framing error with line held low, then a clean frame
    send_frame(8'h11, 1'b0);
    wait_cyc(2 * P);
    uart_rxd = 1'b1;
    wait_cyc(P);
    check("t3_frame_err", rx_bus.frame_err, 1);
    check("t3_status", rx_bus.rx_status, 0);
    check("t3_data_kept", rx_bus.rx_data, 8'hC3);
    send_frame(8'h22, 1'b1);
    check("t3_next_data", rx_bus.rx_data, 8'h22);
    check("t3_next_status", rx_bus.rx_status, 1);
    check("t3_frame_err_sticky", rx_bus.frame_err, 1);
    dir_ack_pulse();
    check("t3_ack_status", rx_bus.rx_status, 0);
    check("t3_ack_frame_err", rx_bus.frame_err, 0);
    check("t3_ack_overrun", rx_bus.overrun, 0);

    // Back-to-back frames, no ack -> overrun
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    check("t4_data", rx_bus.rx_data, 8'h02);
    check("t4_status", rx_bus.rx_status, 1);
    check("t4_overrun", rx_bus.overrun, 1);
    dir_ack_pulse();

    // Ack on the completion cycle of 0x7E while a previous byte is unread
    send_frame(8'h33, 1'b1);
    check("t5_pre_status", rx_bus.rx_status, 1);
    check("t5_pre_overrun", rx_bus.overrun, 0);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        wait_cyc(lat - 1);
        dir_ack = 1'b1;
        wait_cyc(1);
        dir_ack = 1'b0;
      end
    join
    check("t5_status", rx_bus.rx_status, 1);
    check("t5_data", rx_bus.rx_data, 8'h7E);
    check("t5_overrun", rx_bus.overrun, 0);
    check("t5_frame_err", rx_bus.frame_err, 0);

    // Reset at mid bit 4 of 0xFF, then a clean 0x81
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cyc(P / 2 + 5 * P);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
      end
    join
    wait_cyc(P);
    check("t6_rst_data", rx_bus.rx_data, 8'h00);
    check("t6_rst_status", rx_bus.rx_status, 0);
    check("t6_rst_frame_err", rx_bus.frame_err, 0);
    check("t6_rst_overrun", rx_bus.overrun, 0);
    send_frame(8'h81, 1'b1);
    wait_cyc(P);
    check("t6_data", rx_bus.rx_data, 8'h81);
    check("t6_status", rx_bus.rx_status, 1);
    check("t6_overrun", rx_bus.overrun, 0);
    check("t6_frame_err", rx_bus.frame_err, 0);
    dir_ack_pulse();

    // Random frames through the scoreboard; about one in six has a low stop bit
    auto_ack = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      b   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 5) != 0);
      sb_q.push_back('{data: b, err: !stp});
      send_frame(b, stp);
      if (!stp) begin
        wait_cyc(2 * P);
        uart_rxd = 1'b1;
        wait_cyc(P);
      end
      wait_cyc($urandom_range(0, P));
    end
    to = 0;
    while (sb_q.size() != 0 && to < 20 * P) begin
      wait_cyc(1);
      to++;
    end
    check("sb_drained", sb_q.size(), 0);
    wait_cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
